layer_priority_ctrl: RTL and testbench

//  Frame-synchronous scheduler for the VGA object-mux resource. Arbitrates N drawing

---
 rtl/layer_priority_pkg.sv | 30 +++
 rtl/layer_priority_ctrl_prio_pick.sv | 24 ++
 rtl/layer_priority_ctrl.sv | 124 ++++++++++++
 tb/tb_layer_priority_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_priority_pkg.sv
// Shared types and constants for the layer priority scheduler.
// Optional blinking support is selected with LAYER_PRIORITY_BLINK_EN.
package layer_priority_pkg;

    localparam int N_LAYERS  = 12;
    localparam int IDX_W     = $clog2(N_LAYERS);
    localparam int BLINK_BIT = 4;

    typedef logic [IDX_W-1:0] layer_idx_t;

    typedef struct packed {
        layer_idx_t layer;
        logic       enable;
        logic       blink;
    } slot_entry_t;

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} cfg_state_t;

    localparam layer_idx_t BG_WIN_IDX = '0;

    // Power-up table: slot i shows layer i, enabled, not blinking.
    function automatic slot_entry_t identity_entry(input int slot);
        slot_entry_t e;
        e.layer  = layer_idx_t'(slot);
        e.enable = 1'b1;
        e.blink  = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/layer_priority_ctrl_prio_pick.sv
// Combinational first-set finder: reports the lowest slot whose hit bit is set.
module prio_pick
    import layer_priority_pkg::*;
#(
    parameter int N = N_LAYERS
) (
    input  logic [N-1:0] hits,
    output logic         found,
    output layer_idx_t   slot
);

    // Scan from the top down so the lowest set slot is the last one written.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        for (int s = N - 1; s >= 0; s--) begin
            if (hits[s]) begin
                found = 1'b1;
                slot  = layer_idx_t'(s);
            end
        end
    end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Frame-synchronous priority mux for drawing layers with a shadowed, run-time priority table.
// Define LAYER_PRIORITY_BLINK_EN to enable per-slot blinking driven by a frame counter.
module layer_priority_ctrl
    import layer_priority_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [N_LAYERS-1:0]      drawReq,
    input  logic [N_LAYERS-1:0][7:0] layerRGB,
    input  logic [7:0]               backGroundRGB,
    input  logic                     cfgValid,
    output logic                     cfgReady,
    input  logic [IDX_W-1:0]         cfgSlot,
    input  logic [IDX_W-1:0]         cfgLayer,
    input  logic                     cfgEnable,
    input  logic                     cfgBlink,
    output logic [7:0]               rgbOut,
    output logic [IDX_W-1:0]         winLayer,
    output logic                     anyHit
);

    slot_entry_t         active_tbl [N_LAYERS];
    slot_entry_t         shadow_tbl [N_LAYERS];
    cfg_state_t          state;
    slot_entry_t         cfg_entry;
    logic                cfg_accept;
    logic                cfg_in_range;
    logic                blank_phase;
    logic [N_LAYERS-1:0] slot_hit;
    logic                pick_found;
    layer_idx_t          pick_slot;
    layer_idx_t          pick_layer;

`ifdef LAYER_PRIORITY_BLINK_EN
    localparam logic BLINK_STORE = 1'b1;
    logic [5:0] frame_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign blank_phase = frame_cnt[BLINK_BIT];
`else
    localparam logic BLINK_STORE = 1'b0;
    assign blank_phase = 1'b0;
`endif

    // No writes on a commit boundary, so a frame never starts with a half-staged edit.
    assign cfgReady     = (state != COMMIT) && !startOfFrame;
    assign cfg_accept   = cfgValid && cfgReady;
    assign cfg_in_range = (32'(cfgSlot) < N_LAYERS) && (32'(cfgLayer) < N_LAYERS);
    assign cfg_entry    = '{layer: cfgLayer, enable: cfgEnable, blink: cfgBlink & BLINK_STORE};

    always_comb begin
        slot_hit = '0;
        for (int s = 0; s < N_LAYERS; s++) begin
            slot_hit[s] = active_tbl[s].enable && drawReq[active_tbl[s].layer]
                          && !(active_tbl[s].blink && blank_phase);
        end
    end

    prio_pick #(.N(N_LAYERS)) u_pick (
        .hits  (slot_hit),
        .found (pick_found),
        .slot  (pick_slot)
    );

    assign pick_layer = active_tbl[pick_slot].layer;

    // Edits land in the shadow table; the active table only changes in the COMMIT cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            for (int s = 0; s < N_LAYERS; s++) begin
                active_tbl[s] <= identity_entry(s);
                shadow_tbl[s] <= identity_entry(s);
            end
        end else begin
            case (state)
                IDLE, PENDING: begin
                    if (startOfFrame) begin
                        if (state == PENDING) begin
                            state <= COMMIT;
                        end
                    end else if (cfg_accept) begin
                        if (cfg_in_range) begin
                            shadow_tbl[cfgSlot] <= cfg_entry;
                        end
                        state <= PENDING;
                    end
                end
                COMMIT: begin
                    for (int s = 0; s < N_LAYERS; s++) begin
                        active_tbl[s] <= shadow_tbl[s];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgbOut   <= '0;
            winLayer <= BG_WIN_IDX;
            anyHit   <= 1'b0;
        end else if (pick_found) begin
            rgbOut   <= layerRGB[pick_layer];
            winLayer <= pick_layer;
            anyHit   <= 1'b1;
        end else begin
            rgbOut   <= backGroundRGB;
            winLayer <= BG_WIN_IDX;
            anyHit   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Self-checking bench for layer_priority_ctrl: vector table plus hand-written table-edit sequences.
// Blink expectations follow LAYER_PRIORITY_BLINK_EN.
module tb_layer_priority_ctrl;
    import layer_priority_pkg::*;

    typedef struct {
        logic [7:0] rgb;
        layer_idx_t win;
        logic       hit;
    } expect_t;

    typedef struct {
        logic [N_LAYERS-1:0] req;
        logic [7:0]          bg;
        logic [7:0]          rgb;
        layer_idx_t          win;
        logic                hit;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     resetN = 1'b0;
    logic                     startOfFrame = 1'b0;
    logic [N_LAYERS-1:0]      drawReq = '0;
    logic [N_LAYERS-1:0][7:0] layerRGB;
    logic [7:0]               backGroundRGB = '0;
    logic                     cfgValid = 1'b0;
    logic                     cfgReady;
    logic [IDX_W-1:0]         cfgSlot = '0;
    logic [IDX_W-1:0]         cfgLayer = '0;
    logic                     cfgEnable = 1'b0;
    logic                     cfgBlink = 1'b0;
    logic [7:0]               rgbOut;
    logic [IDX_W-1:0]         winLayer;
    logic                     anyHit;

    expect_t    sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         frame_model = 0;
    logic       blink_built;
    logic [7:0] colour [N_LAYERS];
    vec_t       vecs [8];

    layer_priority_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .drawReq       (drawReq),
        .layerRGB      (layerRGB),
        .backGroundRGB (backGroundRGB),
        .cfgValid      (cfgValid),
        .cfgReady      (cfgReady),
        .cfgSlot       (cfgSlot),
        .cfgLayer      (cfgLayer),
        .cfgEnable     (cfgEnable),
        .cfgBlink      (cfgBlink),
        .rgbOut        (rgbOut),
        .winLayer      (winLayer),
        .anyHit        (anyHit)
    );

    always #5 clk = ~clk;

    function automatic expect_t mk(input logic [7:0] rgb, input int win, input logic hit);
        expect_t e;
        e.rgb = rgb;
        e.win = layer_idx_t'(win);
        e.hit = hit;
        return e;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: actual=empty required=entry at %0t", $time);
            return;
        end
        e = sb_q.pop_front();
        checkValue("rgbOut", rgbOut, e.rgb);
        checkValue("winLayer", winLayer, e.win);
        checkValue("anyHit", anyHit, e.hit);
    endtask

    // Drives one cycle of control inputs; expected output is queued now and checked after the edge.
    task automatic applyStimulus(input logic sof, input logic valid, input int slot, input int layer,
                                 input logic en, input logic blink, input int exp_ready, input expect_t e);
        startOfFrame = sof;
        cfgValid     = valid;
        cfgSlot      = IDX_W'(slot);
        cfgLayer     = IDX_W'(layer);
        cfgEnable    = en;
        cfgBlink     = blink;
        sb_q.push_back(e);
        #1;
        if (exp_ready >= 0) checkValue("cfgReady", cfgReady, exp_ready);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int exp_ready, input expect_t e);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, exp_ready, e);
    endtask

    initial begin
`ifdef LAYER_PRIORITY_BLINK_EN
        blink_built = 1'b1;
`else
        blink_built = 1'b0;
`endif
        colour = '{8'hE0, 8'h03, 8'h1C, 8'h25, 8'h4A, 8'h6B, 8'h8C, 8'h92, 8'hB7, 8'hC8, 8'hDB, 8'hFF};
        for (int i = 0; i < N_LAYERS; i++) layerRGB[i] = colour[i];

        vecs[0] = '{12'h005, 8'h00, 8'hE0, 0,  1'b1};
        vecs[1] = '{12'h000, 8'h49, 8'h49, 0,  1'b0};
        vecs[2] = '{12'h004, 8'h49, 8'h1C, 2,  1'b1};
        vecs[3] = '{12'h800, 8'h11, 8'hFF, 11, 1'b1};
        vecs[4] = '{12'hFFE, 8'h11, 8'h03, 1,  1'b1};
        vecs[5] = '{12'h0A0, 8'h11, 8'h6B, 5,  1'b1};
        vecs[6] = '{12'h400, 8'h11, 8'hDB, 10, 1'b1};
        vecs[7] = '{12'h300, 8'h11, 8'hB7, 8,  1'b1};

        #12;
        checkValue("reset rgbOut", rgbOut, 0);
        checkValue("reset winLayer", winLayer, 0);
        checkValue("reset anyHit", anyHit, 0);
        checkValue("reset cfgReady", cfgReady, 1);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Identity table: the lowest requesting layer wins.
        for (int v = 0; v < 8; v++) begin
            drawReq       = vecs[v].req;
            backGroundRGB = vecs[v].bg;
            idle(1, mk(vecs[v].rgb, vecs[v].win, vecs[v].hit));
        end

        // Swap layers 0 and 2; nothing changes until the commit cycle has passed.
        drawReq       = 12'h005;
        backGroundRGB = 8'h49;
        applyStimulus(1'b0, 1'b1, 0, 2, 1'b1, 1'b0, 1, mk(8'hE0, 0, 1));
        applyStimulus(1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1, mk(8'hE0, 0, 1));
        for (int i = 0; i < 3; i++) idle(1, mk(8'hE0, 0, 1));
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'hE0, 0, 1));
        idle(0, mk(8'hE0, 0, 1));
        idle(1, mk(8'h1C, 2, 1));

        // cfgValid held across a frame start: accepted only once back in IDLE.
        applyStimulus(1'b0, 1'b1, 11, 11, 1'b1, 1'b0, 1, mk(8'h1C, 2, 1));
        applyStimulus(1'b1, 1'b1, 0, 2, 1'b0, 1'b0, 0, mk(8'h1C, 2, 1));
        applyStimulus(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 0, mk(8'h1C, 2, 1));
        applyStimulus(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1, mk(8'h1C, 2, 1));
        for (int i = 0; i < 3; i++) idle(1, mk(8'h1C, 2, 1));
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'h1C, 2, 1));
        idle(0, mk(8'h1C, 2, 1));
        idle(1, mk(8'hE0, 0, 1));

        // Layer 2 now lives only in the disabled slot 0.
        drawReq = 12'h004;
        idle(1, mk(8'h49, 0, 0));

        // Out-of-range writes are dropped; a duplicate layer in a lower slot takes over.
        drawReq = 12'h002;
        applyStimulus(1'b0, 1'b1, 1, 14, 1'b1, 1'b0, 1, mk(8'h03, 1, 1));
        applyStimulus(1'b0, 1'b1, 12, 0, 1'b0, 1'b0, 1, mk(8'h03, 1, 1));
        applyStimulus(1'b0, 1'b1, 3, 5, 1'b1, 1'b0, 1, mk(8'h03, 1, 1));
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'h03, 1, 1));
        idle(0, mk(8'h03, 1, 1));
        idle(1, mk(8'h03, 1, 1));
        drawReq = 12'h028;
        idle(1, mk(8'h6B, 5, 1));

        // Frame start while IDLE: no commit cycle follows.
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'h6B, 5, 1));
        idle(1, mk(8'h6B, 5, 1));
        idle(1, mk(8'h6B, 5, 1));

        // Reset while a write is staged: the staged write must be lost.
        drawReq = 12'h005;
        applyStimulus(1'b0, 1'b1, 0, 2, 1'b1, 1'b0, 1, mk(8'hE0, 0, 1));
        cfgValid = 1'b0;
        resetN   = 1'b0;
        #2;
        checkValue("midreset rgbOut", rgbOut, 0);
        checkValue("midreset winLayer", winLayer, 0);
        checkValue("midreset anyHit", anyHit, 0);
        checkValue("midreset cfgReady", cfgReady, 1);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        frame_model = 0;
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'hE0, 0, 1));
        frame_model++;
        idle(1, mk(8'hE0, 0, 1));

        // Blink slot 0 (layer 0); while hidden, layer 2 in slot 2 shows through.
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1, mk(8'hE0, 0, 1));
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, mk(8'hE0, 0, 1));
        frame_model++;
        idle(0, mk(8'hE0, 0, 1));
        for (int f = 0; f < 32; f++) begin
            expect_t e;
            if (blink_built && (((frame_model >> BLINK_BIT) & 1) == 1)) e = mk(8'h1C, 2, 1);
            else e = mk(8'hE0, 0, 1);
            idle(1, e);
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, e);
            frame_model++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
